// File: rtl/ladybird_config.sv
`default_nettype none
// ============================================================================
// Module   : ladybird_config (package)
// Brief    : Shared memory-map definitions for the ladybird core: target
//            enumeration, address-region decode and the decode-error pattern.
// Revision : 1.0
// ============================================================================
package ladybird_config;

  localparam int CFG_XLEN = 32;

  // Read data returned to the master when an address hits no target.
  localparam logic [CFG_XLEN-1:0] DECODE_ERR_DATA = 32'hDEAD_BEEF;

  // Memory-mapped targets; the encoding doubles as the per-target port index.
  typedef enum logic [1:0] {
    DISTRIBUTED_RAM = 2'd0,
    BLOCK_RAM       = 2'd1,
    DYNAMIC_RAM     = 2'd2,
    UART            = 2'd3
  } access_t;

  // Target selected by the top address nibble. Error regions also map to
  // DYNAMIC_RAM here; is_decode_error() tells them apart.
  function automatic access_t access_type(input logic [3:0] addr_region);
    access_t t;
    case (addr_region)
      4'h8:    t = DISTRIBUTED_RAM;
      4'h9:    t = BLOCK_RAM;
      4'hF:    t = UART;
      default: t = DYNAMIC_RAM;
    endcase
    return t;
  endfunction

  // Regions 0xA..0xE are unmapped.
  function automatic logic is_decode_error(input logic [3:0] addr_region);
    return (addr_region >= 4'hA) && (addr_region <= 4'hE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ladybird_bus_router.sv
`default_nettype none
// ============================================================================
// Module   : ladybird_bus_router
// Brief    : 1-to-4 address-decoding router between the core data port and
//            the memory-mapped targets. In-order responses are guaranteed by
//            only ever having one target in flight at a time.
// Revision : 1.0
// ============================================================================
module ladybird_bus_router
  import ladybird_config::*;
#(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 anrst,
  // master side
  input  logic                 m_req_valid,
  output logic                 m_req_ready,
  input  logic [XLEN-1:0]      m_addr,
  input  logic                 m_we,
  input  logic [XLEN/8-1:0]    m_wstrb,
  input  logic [XLEN-1:0]      m_wdata,
  output logic                 m_resp_valid,
  output logic [XLEN-1:0]      m_rdata,
  output logic                 m_err,
  // target side
  output logic [3:0]           s_req_valid,
  input  logic [3:0]           s_req_ready,
  output logic [XLEN-1:0]      s_addr,
  output logic                 s_we,
  output logic [XLEN/8-1:0]    s_wstrb,
  output logic [XLEN-1:0]      s_wdata,
  input  logic [3:0]           s_resp_valid,
  input  logic [3:0][XLEN-1:0] s_rdata
);

  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] count;
  access_t          cur_target;
  logic             err_pending;

  access_t          decoded;
  logic             dec_err;
  logic             accept_ok;
  logic             err_ok;
  logic             target_accept;
  logic             err_accept;
  logic             resp_hit;
  logic [3:0]       cur_onehot;

  // Master request fields are broadcast; only s_req_valid selects a target.
  assign s_addr  = m_addr;
  assign s_we    = m_we;
  assign s_wstrb = m_wstrb;
  assign s_wdata = m_wdata;

  // Address decode and admission: a new target waits until the previous
  // one has fully drained, and nothing is admitted while an error answers.
  always_comb begin
    decoded   = access_type(m_addr[XLEN-1 -: 4]);
    dec_err   = is_decode_error(m_addr[XLEN-1 -: 4]);
    accept_ok = anrst & ~err_pending & (count < MAX_CNT) &
                ((count == '0) | (decoded == cur_target));
    err_ok    = anrst & ~err_pending & (count == '0);
  end

  // Request routing and master ready.
  always_comb begin
    s_req_valid = 4'b0000;
    m_req_ready = 1'b0;
    if (dec_err) begin
      m_req_ready = err_ok;
    end else begin
      m_req_ready          = accept_ok & s_req_ready[decoded];
      s_req_valid[decoded] = m_req_valid & accept_ok;
    end
  end

  // Handshake events; a response with nothing outstanding is ignored.
  always_comb begin
    target_accept = m_req_valid & m_req_ready & ~dec_err;
    err_accept    = m_req_valid & m_req_ready & dec_err;
    resp_hit      = s_resp_valid[cur_target] & (count != '0);
    cur_onehot    = 4'b0001 << cur_target;
  end

  // Outstanding-transaction bookkeeping: count, active target, error flag.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      count       <= '0;
      cur_target  <= DISTRIBUTED_RAM;
      err_pending <= 1'b0;
    end else begin
      if (target_accept) begin
        cur_target <= decoded;
      end
      case ({target_accept, resp_hit})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      err_pending <= err_accept;
    end
  end

  // Registered response: target data one cycle after its pulse, or the
  // error pattern one cycle after an unmapped request is accepted.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      m_resp_valid <= 1'b0;
      m_rdata      <= '0;
      m_err        <= 1'b0;
    end else begin
      m_resp_valid <= 1'b0;
      m_err        <= 1'b0;
      if (resp_hit) begin
        m_resp_valid <= 1'b1;
        m_rdata      <= s_rdata[cur_target];
      end else if (err_accept) begin
        m_resp_valid <= 1'b1;
        m_err        <= 1'b1;
        m_rdata      <= DECODE_ERR_DATA;
      end
    end
  end

  // Only the target currently being served may answer.
  a_resp_from_current_target : assert property (
    @(posedge clk) disable iff (!anrst) ((s_resp_valid & ~cur_onehot) == 4'b0000)
  );

endmodule
`default_nettype wire

// File: tb/tb_ladybird_bus_router.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ladybird_bus_router
// Brief    : Randomized scoreboard bench for ladybird_bus_router with
//            behavioural target models and an in-order response queue.
// Revision : 1.0
// ============================================================================
module tb_ladybird_bus_router;

  localparam int XLEN = 32;
  localparam int MAXO = 4;

  logic                 clk = 1'b0;
  logic                 anrst = 1'b0;
  logic                 m_req_valid;
  logic                 m_req_ready;
  logic [XLEN-1:0]      m_addr;
  logic                 m_we;
  logic [XLEN/8-1:0]    m_wstrb;
  logic [XLEN-1:0]      m_wdata;
  logic                 m_resp_valid;
  logic [XLEN-1:0]      m_rdata;
  logic                 m_err;
  logic [3:0]           s_req_valid;
  logic [3:0]           s_req_ready;
  logic [XLEN-1:0]      s_addr;
  logic                 s_we;
  logic [XLEN/8-1:0]    s_wstrb;
  logic [XLEN-1:0]      s_wdata;
  logic [3:0]           s_resp_valid;
  logic [3:0][XLEN-1:0] s_rdata;

  ladybird_bus_router #(.XLEN(XLEN), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .anrst(anrst),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_addr(m_addr), .m_we(m_we), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
    .m_resp_valid(m_resp_valid), .m_rdata(m_rdata), .m_err(m_err),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_addr(s_addr), .s_we(s_we), .s_wstrb(s_wstrb), .s_wdata(s_wdata),
    .s_resp_valid(s_resp_valid), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic err; logic [31:0] data; } resp_t;
  typedef struct packed { logic [31:0] data; int due; } pend_t;

  resp_t exp_q[$];      // expected master responses, in order
  pend_t slv_q[4][$];   // per-target requests awaiting a response

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cycle    = 0;
  // reference model state
  int  mdl_cnt  = 0;
  int  mdl_tgt  = 0;
  bit  mdl_errcyc = 1'b0;
  bit  acc      = 1'b0;
  // stimulus knobs
  bit  stop_req = 1'b0;
  bit  req_active = 1'b0;
  int  p_req  = 70;
  int  p_rdy  = 75;
  int  p_resp = 60;
  logic [3:0] last_nib = 4'h8;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory map from the address-region rules; -1 means unmapped.
  function automatic int model_target(input logic [31:0] a);
    int region = int'(a[31:28]);
    if (region == 8)  return 0;
    if (region == 9)  return 1;
    if (region == 15) return 3;
    if (region >= 10 && region <= 14) return -1;
    return 2;
  endfunction

  task automatic new_request();
    logic [3:0] nib;
    int r = $urandom_range(0, 99);
    if (r < 50) begin
      nib = last_nib;
    end else begin
      r = $urandom_range(0, 15);
      if (r < 4)       nib = 4'h8;
      else if (r < 7)  nib = 4'h9;
      else if (r < 10) nib = 4'hF;
      else if (r == 10) nib = 4'($urandom_range(10, 14));
      else             nib = 4'($urandom_range(0, 7));
    end
    last_nib    = nib;
    m_addr      = {nib, 28'($urandom)};
    m_we        = 1'($urandom);
    m_wstrb     = 4'($urandom);
    m_wdata     = $urandom;
    m_req_valid = 1'b1;
    req_active  = 1'b1;
  endtask

  // Master and target stimulus, driven just after each rising edge.
  always @(posedge clk) begin
    #1;
    cycle++;
    if (!anrst) begin
      m_req_valid  = 1'b0;
      req_active   = 1'b0;
      s_resp_valid = 4'b0000;
      for (int t = 0; t < 4; t++) slv_q[t].delete();
      s_req_ready  = 4'($urandom);
    end else begin
      if (acc) req_active = 1'b0;
      if (!req_active) begin
        if (!stop_req && $urandom_range(0, 99) < p_req) new_request();
        else m_req_valid = 1'b0;
      end
      for (int t = 0; t < 4; t++) begin
        s_req_ready[t] = ($urandom_range(0, 99) < p_rdy);
        if (slv_q[t].size() > 0 && slv_q[t][0].due <= cycle &&
            $urandom_range(0, 99) < p_resp) begin
          s_resp_valid[t] = 1'b1;
          s_rdata[t]      = slv_q[t][0].data;
          void'(slv_q[t].pop_front());
        end else begin
          s_resp_valid[t] = 1'b0;
          s_rdata[t]      = $urandom;
        end
      end
    end
  end

  // Reference model: predict ready/routing for this cycle, then advance.
  always @(negedge clk) begin
    int   dt, dti;
    bit   derr, ok_t, rdy_exp, resp_hit;
    logic [3:0] sv_exp;
    logic [31:0] d;
    #1;
    if (!anrst) begin
      check("rst_m_resp_valid", m_resp_valid, 0);
      check("rst_m_rdata", m_rdata, 0);
      check("rst_m_err", m_err, 0);
      check("rst_s_req_valid", s_req_valid, 0);
      mdl_cnt = 0; mdl_tgt = 0; mdl_errcyc = 1'b0; acc = 1'b0;
      exp_q.delete();
    end else begin
      dt   = model_target(m_addr);
      derr = (dt < 0);
      dti  = derr ? 0 : dt;
      ok_t = !mdl_errcyc && mdl_cnt < MAXO && (mdl_cnt == 0 || dt == mdl_tgt);
      rdy_exp = derr ? (!mdl_errcyc && mdl_cnt == 0) : (ok_t && s_req_ready[dti]);
      sv_exp  = (!derr && m_req_valid && ok_t) ? (4'b0001 << dti) : 4'b0000;
      check("m_req_ready", m_req_ready, rdy_exp);
      check("s_req_valid", s_req_valid, sv_exp);
      if (m_req_valid)
        check("broadcast", {s_addr, s_we, s_wstrb, s_wdata}, {m_addr, m_we, m_wstrb, m_wdata});
      resp_hit = (mdl_cnt > 0) && s_resp_valid[mdl_tgt];
      acc      = m_req_valid && rdy_exp;
      if (acc && derr) exp_q.push_back({1'b1, 32'hDEAD_BEEF});
      if (acc && !derr) begin
        d = $urandom;
        slv_q[dti].push_back({d, cycle + 1 + int'($urandom_range(0, 2))});
        exp_q.push_back({1'b0, d});
        mdl_tgt = dti;
      end
      mdl_errcyc = acc && derr;
      mdl_cnt    = mdl_cnt + ((acc && !derr) ? 1 : 0) - (resp_hit ? 1 : 0);
    end
  end

  // Monitor: every master response must match the head of the scoreboard.
  always @(negedge clk) begin
    resp_t e;
    if (anrst && m_resp_valid) begin
      check("resp_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("resp_err", m_err, e.err);
        check("resp_rdata", m_rdata, e.data);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    bit done;
    m_req_valid = 1'b0; m_addr = '0; m_we = 1'b0; m_wstrb = '0; m_wdata = '0;
    s_req_ready = 4'b0000; s_resp_valid = 4'b0000; s_rdata = '0;
    run(3);
    @(negedge clk); #3 anrst = 1'b1;
    run(1200);
    // withhold responses so the outstanding limit is exercised
    p_resp = 5; p_rdy = 95; p_req = 95;
    run(400);
    p_resp = 60; p_rdy = 75; p_req = 70;
    run(300);
    // reset in the middle of traffic
    @(negedge clk); #3 anrst = 1'b0;
    run(3);
    @(negedge clk); #3 anrst = 1'b1;
    // slow targets
    p_rdy = 30; p_resp = 40;
    run(1000);
    p_rdy = 75; p_resp = 60;
    run(600);
    // drain
    stop_req = 1'b1; p_rdy = 100; p_resp = 100;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      done = !req_active && exp_q.size() == 0 && mdl_cnt == 0;
    end
    check("drain_complete", done, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
